// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard tracking in-flight destinations across DEPTH post-decode stages.
// Forwarding muxes are enabled by defining SCOREBOARD_FWD_EN; otherwise every RAW hazard stalls until WB.
module pipe_scoreboard #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned LOAD_READY = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          issue_valid,
   input  logic                          issue_flush,
   input  logic [REG_ADDR_W-1:0]         issue_rd,
   input  logic                          issue_regwrite,
   input  logic                          issue_is_load,
   input  logic [REG_ADDR_W-1:0]         src_a,
   input  logic [REG_ADDR_W-1:0]         src_b,
   input  logic                          src_a_used,
   input  logic                          src_b_used,
   output logic                          stall,
   output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_a,
   output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_b,
   output logic [$clog2(DEPTH+1)-1:0]    inflight,
   output logic [CNT_W-1:0]              stall_cycles
);

   localparam int unsigned SEL_W = $clog2(DEPTH + 1);

   logic [DEPTH:1]        entV;
   logic [REG_ADDR_W-1:0] entRd [1:DEPTH];
   logic [DEPTH:1]        nextV;
   logic [SEL_W-1:0]      youngA;
   logic [SEL_W-1:0]      youngB;
   logic                  hazA;
   logic                  hazB;
   logic                  issueV;

`ifdef SCOREBOARD_FWD_EN
   logic [DEPTH:1]        entLd;
   logic                  ldA;
   logic                  ldB;
`else
   logic                  unusedLoad;
   assign unusedLoad = issue_is_load;
`endif

   // Youngest matching producer per operand; scanning oldest-first lets the youngest overwrite.
   always_comb begin : resolve
      youngA = '0;
      youngB = '0;
`ifdef SCOREBOARD_FWD_EN
      ldA = 1'b0;
      ldB = 1'b0;
`endif
      for (int k = int'(DEPTH); k >= 1; k--) begin
         if (entV[k] && (entRd[k] == src_a) && (src_a != '0) && src_a_used) begin
            youngA = SEL_W'(k);
`ifdef SCOREBOARD_FWD_EN
            ldA = entLd[k];
`endif
         end
         if (entV[k] && (entRd[k] == src_b) && (src_b != '0) && src_b_used) begin
            youngB = SEL_W'(k);
`ifdef SCOREBOARD_FWD_EN
            ldB = entLd[k];
`endif
         end
      end
   end

`ifdef SCOREBOARD_FWD_EN
   // Only a load whose data is not yet available can block the youngest match.
   assign hazA = ldA && (youngA != '0) && (int'(youngA) < int'(LOAD_READY));
   assign hazB = ldB && (youngB != '0) && (int'(youngB) < int'(LOAD_READY));
`else
   // Without bypass, any producer short of WB blocks; the youngest match is the earliest stage.
   assign hazA = (youngA != '0) && (int'(youngA) < int'(DEPTH));
   assign hazB = (youngB != '0) && (int'(youngB) < int'(DEPTH));
`endif

   assign stall = issue_valid && !issue_flush && (hazA || hazB);

`ifdef SCOREBOARD_FWD_EN
   assign fwd_sel_a = stall ? '0 : youngA;
   assign fwd_sel_b = stall ? '0 : youngB;
`else
   assign fwd_sel_a = '0;
   assign fwd_sel_b = '0;
`endif

   assign issueV = issue_valid && issue_regwrite && !issue_flush && !stall && (issue_rd != '0);

   always_comb begin : shiftValid
      nextV    = '0;
      nextV[1] = issueV;
      for (int k = 2; k <= int'(DEPTH); k++) begin
         nextV[k] = entV[k-1];
      end
   end

   // Entries always advance; stalls and flushes enter as bubbles rather than freezing the pipe.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         entV         <= '0;
         inflight     <= '0;
         stall_cycles <= '0;
         for (int k = 1; k <= int'(DEPTH); k++) begin
            entRd[k] <= '0;
         end
`ifdef SCOREBOARD_FWD_EN
         entLd <= '0;
`endif
      end else begin
         entV     <= nextV;
         inflight <= SEL_W'($countones(nextV));
         entRd[1] <= issue_rd;
         for (int k = 2; k <= int'(DEPTH); k++) begin
            entRd[k] <= entRd[k-1];
         end
`ifdef SCOREBOARD_FWD_EN
         entLd[1] <= issue_is_load;
         for (int k = 2; k <= int'(DEPTH); k++) begin
            entLd[k] <= entLd[k-1];
         end
`endif
         if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: directed hazard scenarios followed by random traffic against a queue model.
module tb_pipe_scoreboard;

   localparam int DEPTH      = 3;
   localparam int LOAD_READY = 2;
   localparam int AW         = 5;
   localparam int CW         = 16;
   localparam int SW         = $clog2(DEPTH + 1);

   logic          Clk = 1'b0;
   logic          Reset;
   logic          issue_valid, issue_flush, issue_regwrite, issue_is_load;
   logic [AW-1:0] issue_rd, src_a, src_b;
   logic          src_a_used, src_b_used;
   logic          stall;
   logic [SW-1:0] fwd_sel_a, fwd_sel_b, inflight;
   logic [CW-1:0] stall_cycles;

   pipe_scoreboard #(.REG_ADDR_W(AW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .CNT_W(CW)) dut (
      .Clk(Clk), .Reset(Reset),
      .issue_valid(issue_valid), .issue_flush(issue_flush), .issue_rd(issue_rd),
      .issue_regwrite(issue_regwrite), .issue_is_load(issue_is_load),
      .src_a(src_a), .src_b(src_b), .src_a_used(src_a_used), .src_b_used(src_b_used),
      .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .inflight(inflight), .stall_cycles(stall_cycles)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit v;
      int rd;
      bit ld;
   } ent_t;

   ent_t          pipe[$];       // index 0 = EX (stage 1)
   int            expCycles;
   bit            rstReq;
   int            checks = 0;
   int            errors = 0;
   logic          obsStall;
   logic [SW-1:0] obsSelA, obsSelB, obsInflight;
   logic [CW-1:0] obsCycles;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelClear();
      ent_t e;
      e.v = 1'b0; e.rd = 0; e.ld = 1'b0;
      pipe.delete();
      for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
      expCycles = 0;
   endtask

   // Stage number (1-based) of the youngest valid producer of src, 0 if none.
   function automatic int youngest(input int src, input bit used, output bit ld);
      ld = 1'b0;
      if (!used || src == 0) return 0;
      foreach (pipe[i]) begin
         if (pipe[i].v && pipe[i].rd == src) begin
            ld = pipe[i].ld;
            return i + 1;
         end
      end
      return 0;
   endfunction

   task automatic step(input bit v, input bit f, input int rd, input bit rw, input bit ld,
                       input int a, input bit au, input int b, input bit bu);
      int   ka, kb, sa, sb, pop;
      bit   la, lb, ha, hb, expStall;
      ent_t e;
      Reset = rstReq;
      issue_valid = v; issue_flush = f; issue_rd = AW'(rd);
      issue_regwrite = rw; issue_is_load = ld;
      src_a = AW'(a); src_a_used = au; src_b = AW'(b); src_b_used = bu;
      #1;
      ka = youngest(a, au, la);
      kb = youngest(b, bu, lb);
`ifdef SCOREBOARD_FWD_EN
      ha = (ka != 0) && la && (ka < LOAD_READY);
      hb = (kb != 0) && lb && (kb < LOAD_READY);
`else
      ha = (ka != 0) && (ka < DEPTH);
      hb = (kb != 0) && (kb < DEPTH);
`endif
      expStall = v && !f && (ha || hb);
`ifdef SCOREBOARD_FWD_EN
      sa = expStall ? 0 : ka;
      sb = expStall ? 0 : kb;
`else
      sa = 0;
      sb = 0;
`endif
      pop = 0;
      foreach (pipe[i]) if (pipe[i].v) pop++;
      obsStall = stall; obsSelA = fwd_sel_a; obsSelB = fwd_sel_b;
      obsInflight = inflight; obsCycles = stall_cycles;
      chk("stall", obsStall, expStall);
      chk("fwd_sel_a", obsSelA, sa);
      chk("fwd_sel_b", obsSelB, sb);
      chk("inflight", obsInflight, pop);
      chk("stall_cycles", obsCycles, expCycles);
      @(posedge Clk);
      if (rstReq) begin
         modelClear();
      end else begin
         e.v = v && rw && !f && !expStall && (rd != 0);
         e.rd = rd; e.ld = ld;
         pipe.push_front(e);
         void'(pipe.pop_back());
         if (expStall && expCycles < (1 << CW) - 1) expCycles++;
      end
      @(negedge Clk);
   endtask

   // Re-present an instruction until it is accepted, bounded to a few cycles.
   task automatic issueUntilGo(input int rd, input int a, input bit au, input int b, input bit bu,
                               output int stalls);
      stalls = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, rd, 1, 0, a, au, b, bu);
         if (obsStall !== 1'b1) break;
         stalls++;
      end
   endtask

   initial begin
      int n;
      Reset = 1'b1; rstReq = 1'b0;
      issue_valid = 0; issue_flush = 0; issue_rd = '0; issue_regwrite = 0; issue_is_load = 0;
      src_a = '0; src_b = '0; src_a_used = 0; src_b_used = 0;
      repeat (2) @(posedge Clk);
      modelClear();
      @(negedge Clk);

      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_stall", obsStall, 0);
      chk("rst_inflight", obsInflight, 0);
      chk("rst_cycles", obsCycles, 0);

      // add $3 then a reader of $3
      step(1, 0, 3, 1, 0, 0, 0, 0, 0);
      issueUntilGo(8, 3, 1, 0, 0, n);
`ifdef SCOREBOARD_FWD_EN
      chk("alu_fwd_stalls", n, 0);
      chk("alu_fwd_sel", obsSelA, 1);
      step(1, 0, 9, 1, 0, 0, 0, 0, 0);
      chk("alu_inflight2", obsInflight, 2);
`else
      chk("nofwd_stalls", n, 2);
      chk("nofwd_sel", obsSelA, 0);
      step(1, 0, 9, 1, 0, 0, 0, 0, 0);
`endif

      // load-use on src_b
      rstReq = 1'b1; step(0, 0, 0, 0, 0, 0, 0, 0, 0); rstReq = 1'b0;
      step(1, 0, 5, 1, 1, 0, 0, 0, 0);
      issueUntilGo(6, 0, 0, 5, 1, n);
`ifdef SCOREBOARD_FWD_EN
      chk("ld_use_stalls", n, 1);
      chk("ld_use_sel_b", obsSelB, 2);
      chk("ld_use_cycles", obsCycles, 1);
`else
      chk("ld_use_stalls", n, 2);
      chk("ld_use_cycles", obsCycles, 2);
`endif

      // two producers of $7: the youngest wins
      step(1, 0, 7, 1, 0, 0, 0, 0, 0);
      step(1, 0, 7, 1, 0, 0, 0, 0, 0);
      issueUntilGo(10, 7, 1, 0, 0, n);
`ifdef SCOREBOARD_FWD_EN
      chk("young_stalls", n, 0);
      chk("young_sel", obsSelA, 1);
`else
      chk("young_stalls", n, 2);
`endif

      // writes to $0 never become producers
      step(1, 0, 0, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 1, 0, 0, 0, 0);
      issueUntilGo(11, 0, 1, 0, 1, n);
      chk("zero_stalls", n, 0);
      chk("zero_sel_a", obsSelA, 0);
      chk("zero_sel_b", obsSelB, 0);
      chk("zero_inflight", obsInflight, 1);

      // flushed reader does not stall; reset clears a live stall
      step(1, 0, 4, 1, 1, 0, 0, 0, 0);
      step(1, 1, 12, 1, 0, 4, 1, 0, 0);
      chk("flush_stall", obsStall, 0);
      step(1, 0, 4, 1, 1, 0, 0, 0, 0);
      step(1, 0, 12, 1, 0, 4, 1, 0, 0);
      chk("pre_rst_stall", obsStall, 1);
      rstReq = 1'b1;
      step(1, 0, 12, 1, 0, 4, 1, 0, 0);
      chk("rst_cycle_stall", obsStall, 1);
      rstReq = 1'b0;
      step(1, 0, 12, 1, 0, 4, 1, 0, 0);
      chk("post_rst_stall", obsStall, 0);
      chk("post_rst_inflight", obsInflight, 0);
      chk("post_rst_cycles", obsCycles, 0);

      // random traffic over a small register window to provoke hazards
      repeat (400) begin
         bit rv, rf, rw, rl, au, bu;
         int rd, a, b;
         rstReq = ($urandom_range(0, 49) == 0);
         rv = ($urandom_range(0, 99) < 85);
         rf = ($urandom_range(0, 9) == 0);
         rw = ($urandom_range(0, 3) != 0);
         rl = rw && ($urandom_range(0, 2) == 0);
         rd = int'($urandom_range(0, 7));
         a  = int'($urandom_range(0, 7));
         b  = int'($urandom_range(0, 7));
         au = ($urandom_range(0, 3) != 0);
         bu = ($urandom_range(0, 1) != 0);
         step(rv, rf, rd, rw, rl, a, au, b, bu);
      end
      rstReq = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised hazard and forwarding unit for the pipelined core. Replaces the fixed stall-only hazard detection.
- Tracks in-flight destination registers across DEPTH post-decode stages (EX, MEM, WB, …) in a shift register.
- Produces per-operand forward selects, a decode stall, and a saturating stall-cycle counter.
- Sits beside the decode stage. Its outputs drive the decode/PC write enables, the control bubble mux, and the EX operand muxes.

Parameters:
- REG_ADDR_W, 5: register index width. Register 0 is hardwired zero.
- DEPTH, 3: number of tracked stages after decode. Stage 1 = EX, stage DEPTH = WB.
- LOAD_READY, 2: first stage index at which load data can be forwarded.
- CNT_W, 16: stall counter width.

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- issue_valid  in  1  decode holds a valid instruction
- issue_flush  in  1  decode instruction is squashed (branch/jump taken)
- issue_rd  in  REG_ADDR_W  destination of decode instruction
- issue_regwrite  in  1  decode instruction writes issue_rd
- issue_is_load  in  1  decode instruction is a load
- src_a, src_b  in  REG_ADDR_W  decode source registers (rs, rt)
- src_a_used, src_b_used  in  1  source is actually read
- stall  out  1  hold PC and Fetch_To_Decode; insert a bubble into EX
- fwd_sel_a, fwd_sel_b  out  $clog2(DEPTH+1)  0 = register file, k = stage k result
- inflight  out  $clog2(DEPTH+1)  count of valid tracked entries
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- State: DEPTH entries {v, rd, ld}, index 1..DEPTH. Entry 1 is the youngest.
- Every clock edge, entries shift: entry k+1 <= entry k. Entry DEPTH retires.
- Entry 1 loads {issue_valid & issue_regwrite & ~issue_flush & ~stall & (issue_rd != 0), issue_rd, issue_is_load}.
  - A stall or flush therefore inserts a bubble (v=0).
  - The older entries never freeze.
- Match(k, s): v_k & (rd_k == s) & (s != 0) & used.
- Forwarding, combinational from current state and inputs:
  - fwd_sel = smallest k with Match(k, s), i.e. the youngest producer wins. 0 if no match.
  - fwd_sel is forced to 0 while stall=1.
- Stall, combinational:
  - stall = issue_valid & ~issue_flush & (∃ operand whose youngest match k has ld_k=1 and k < LOAD_READY).
  - An older non-load match hidden behind a younger load still stalls.
- Load-use with defaults: load in EX (k=1) stalls 1 cycle. Next cycle the load is at k=2 and forwards from MEM.
- issue_flush with a hazard: no stall; the bubble enters.
- Simultaneous rd match on both operands: each operand is resolved independently. stall is their OR.
- inflight: population count of v bits, registered-state based.
- stall_cycles increments when stall=1 and holds at 2^CNT_W−1.
- Reset, sampled on Clk when high:
  - All v=0, rd=0, ld=0, stall_cycles=0.
  - Outputs stall=0, fwd_sel_a=fwd_sel_b=0, inflight=0 in the cycle after reset is sampled.
  - Reset mid-stall clears the stall immediately at that edge.
- issue_valid=0: stall=0, and a bubble is inserted.

Optional Feature:
- Macro: SCOREBOARD_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - fwd_sel_a/b are tied to 0.
  - stall asserts on any Match(k, s) with k < DEPTH; WB is still written before read.
  - Loads are treated like any producer.

Test Plan:
- Reset, then issue `add $3` followed by `sub` reading $3 → fwd_sel_a=1, stall=0. The next cycle with an unrelated instruction shows inflight=2.
- `lw $5`, then `add` reading $5 as src_b → stall=1 for exactly 1 cycle and stall_cycles=1. The retried add gets fwd_sel_b=2, stall=0.
- `add $7`, `add $7`, then a reader of $7 → fwd_sel=1, the youngest producer, not 2.
- Writes to $0 followed by a reader of $0 → no entry marked valid, fwd_sel=0, stall=0.
- `lw $4`, then a reader of $4 with issue_flush=1 → stall=0 and the bubble enters. Assert Reset during a forced stall → stall=0, inflight=0 and stall_cycles=0 on the next cycle.
- With SCOREBOARD_FWD_EN undefined: `add $3`, then a reader of $3 → stall=1 for 2 cycles, then proceeds with fwd_sel=0.
